fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream.sv | 43 ++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read port into a 2-entry valid/ready output buffer
module fifo_rd_stream #(
    parameter int DSIZE = 32,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] beats
);
    logic [DSIZE-1:0] head, tail;
    logic push, pop;
    // push depends only on registered occ, so m_ready never reaches rinc
    assign push    = !rrst && !rempty && (occ != 2'd2);
    assign pop     = m_valid && m_ready;
    assign rinc    = push;
    assign m_valid = occ != 2'd0;
    assign m_data  = head;
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            head  <= '0;
            tail  <= '0;
            occ   <= '0;
            beats <= '0;
        end else begin
            if (push && (occ == 2'd0 || pop))
                head <= rdata;
            else if (pop && occ == 2'd2)
                head <= tail;
            if (push && !pop && occ == 2'd1)
                tail <= rdata;
            occ <= occ + 2'(push) - 2'(pop);
            if (pop)
                beats <= beats + CNT_W'(1);
        end
    end
endmodule
